// File: rtl/timer_8bit_core.sv
// 8-bit programmable timer: req/ack register file, /1-/8 prescaler, up/down
// counter with parallel load, sticky OVF/UDF flags gated into two interrupts.
module timer_8bit_core #(
    parameter int         ADDR_W  = 8,
    parameter logic [7:0] RST_CNT = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              ack,
    output logic              int_ovf,
    output logic              int_udf
);

    localparam logic [2:0] A_TDR  = 3'd0;
    localparam logic [2:0] A_TCR  = 3'd1;
    localparam logic [2:0] A_TSR  = 3'd2;
    localparam logic [2:0] A_TIER = 3'd3;
    localparam logic [2:0] A_TCNT = 3'd4;

    logic [7:0] r_tdr, r_tcnt, r_rdata;
    logic [1:0] r_cks;
    logic       r_en, r_dn, r_load;
    logic       r_ovf, r_udf, r_ovfe, r_udfe;
    logic       r_ack;
    logic [2:0] r_psc;

    logic       w_addr_rsvd, w_wr;
    logic       w_wr_tdr, w_wr_tcr, w_wr_tsr, w_wr_tier;
    logic       w_cks_chg, w_psc_run, w_tick;
    logic       w_ovf_set, w_udf_set;
    logic [2:0] w_psc_max;
    logic [7:0] w_rd_mux;

    // Any address bit above bit 2 makes the whole access reserved.
    assign w_addr_rsvd = (addr >> 3) != '0;
    assign w_wr        = req & we & ~w_addr_rsvd;
    assign w_wr_tdr    = w_wr & (addr[2:0] == A_TDR);
    assign w_wr_tcr    = w_wr & (addr[2:0] == A_TCR);
    assign w_wr_tsr    = w_wr & (addr[2:0] == A_TSR);
    assign w_wr_tier   = w_wr & (addr[2:0] == A_TIER);

    assign w_cks_chg = w_wr_tcr & (wdata[1:0] != r_cks);
    assign w_psc_run = r_en & ~r_load & ~w_cks_chg;
    assign w_tick    = w_psc_run & (r_psc == w_psc_max);

    assign w_ovf_set = w_tick & ~r_dn & (r_tcnt == 8'hFF);
    assign w_udf_set = w_tick &  r_dn & (r_tcnt == 8'h00);

    always_comb begin
        // NOTE: every always_comb output is given a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        w_psc_max = 3'd0;
        case (r_cks)
            2'd0:    w_psc_max = 3'd0;
            2'd1:    w_psc_max = 3'd1;
            2'd2:    w_psc_max = 3'd3;
            default: w_psc_max = 3'd7;
        endcase
    end

    always_comb begin
        w_rd_mux = 8'h00;
        if (!w_addr_rsvd) begin
            case (addr[2:0])
                A_TDR:   w_rd_mux = r_tdr;
                A_TCR:   w_rd_mux = {r_load, 1'b0, r_dn, r_en, 2'b00, r_cks};
                A_TSR:   w_rd_mux = {6'b0, r_udf, r_ovf};
                A_TIER:  w_rd_mux = {6'b0, r_udfe, r_ovfe};
                A_TCNT:  w_rd_mux = r_tcnt;
                default: w_rd_mux = 8'h00;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tdr  <= RST_CNT;
            r_cks  <= 2'd0;
            r_en   <= 1'b0;
            r_dn   <= 1'b0;
            r_load <= 1'b0;
            r_ovfe <= 1'b0;
            r_udfe <= 1'b0;
        end else begin
            if (w_wr_tdr) r_tdr <= wdata;
            if (w_wr_tcr) begin
                r_cks  <= wdata[1:0];
                r_en   <= wdata[4];
                r_dn   <= wdata[5];
                r_load <= wdata[7];
            end
            if (w_wr_tier) begin
                r_ovfe <= wdata[0];
                r_udfe <= wdata[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_psc  <= 3'd0;
            r_tcnt <= RST_CNT;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            if (!w_psc_run || w_tick) r_psc <= 3'd0;
            else                      r_psc <= r_psc + 3'd1;

            if (r_load)      r_tcnt <= r_tdr;
            else if (w_tick) r_tcnt <= r_dn ? r_tcnt - 8'd1 : r_tcnt + 8'd1;

            // A flag being set on the same edge as its W1C stays set.
            r_ovf <= w_ovf_set | (r_ovf & ~(w_wr_tsr & wdata[0]));
            r_udf <= w_udf_set | (r_udf & ~(w_wr_tsr & wdata[1]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_ack   <= req;
            r_rdata <= (req && !we) ? w_rd_mux : 8'h00;
        end
    end

    assign ack     = r_ack;
    assign rdata   = r_rdata;
    assign int_ovf = r_ovf & r_ovfe;
    assign int_udf = r_udf & r_udfe;

endmodule

// File: tb/tb_timer_8bit_core.sv
// Self-checking bench for timer_8bit_core: table-driven register accesses,
// hand-written counting sequences, and a read-data scoreboard checked on ack.
module tb_timer_8bit_core;

    localparam logic [7:0] TDR  = 8'h00;
    localparam logic [7:0] TCR  = 8'h01;
    localparam logic [7:0] TSR  = 8'h02;
    localparam logic [7:0] TIER = 8'h03;
    localparam logic [7:0] TCNT = 8'h04;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       we  = 1'b0;
    logic [7:0] addr  = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       ack, int_ovf, int_udf;

    timer_8bit_core #(.ADDR_W(8), .RST_CNT(8'h00)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ack     (ack),
        .int_ovf (int_ovf),
        .int_udf (int_udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       chk;
        logic [7:0] data;
        string      name;
    } exp_t;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_ack = 1'b0;
    logic started = 1'b0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference ack: one cycle after every req cycle, dropped by reset.
    always @(posedge clk) exp_ack <= req && !rst;

    always @(negedge clk) begin
        if (started) begin
            check("ack_timing", {7'b0, ack}, {7'b0, exp_ack});
            if (ack) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: ack with no outstanding request (t=%0t)", $time);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.chk) check(mon_e.name, rdata, mon_e.data);
                end
            end else begin
                check("rdata_idle", rdata, 8'h00);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic bus(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] x, input string nm);
        exp_t t;
        req = 1'b1; we = w; addr = a; wdata = d;
        t.chk = ~w; t.data = x; t.name = nm;
        sb.push_back(t);
        step();
        req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus(1'b1, a, d, 8'h00, "wr");
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] x, input string nm);
        bus(1'b0, a, 8'h00, x, nm);
    endtask

    task automatic do_reset();
        idle(1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic w, input logic [7:0] a,
                                input logic [7:0] d, input logic [7:0] x);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.exp = x;
        return v;
    endfunction

    // Up count from FD through the FF->00 wrap, with or without OVFE.
    task automatic run_up(input logic [7:0] tier);
        do_reset();
        wr(TIER, tier);
        wr(TDR, 8'hFD);
        wr(TCR, 8'h80);
        wr(TCR, 8'h10);
        rd(TCNT, 8'hFD, "up_fd");
        rd(TCNT, 8'hFE, "up_fe");
        check("up_int_before_wrap", {7'b0, int_ovf}, 8'h00);
        rd(TCNT, 8'hFF, "up_ff");
        check("up_int_after_wrap", {7'b0, int_ovf}, {7'b0, tier[0]});
        rd(TCNT, 8'h00, "up_00");
        rd(TSR, 8'h01, "up_tsr_ovf");
        check("up_int_udf_quiet", {7'b0, int_udf}, 8'h00);
    endtask

    // Counter advances once per N cycles after the commit of EN=1.
    task automatic presc(input logic [1:0] cks);
        int n;
        n = 1 << cks;
        do_reset();
        wr(TCR, 8'h10 | {6'b0, cks});
        idle(n - 1);
        rd(TCNT, 8'h00, $sformatf("psc%0d_before_1st", n));
        rd(TCNT, 8'h01, $sformatf("psc%0d_1st_tick", n));
        idle(n - 2);
        rd(TCNT, 8'h01, $sformatf("psc%0d_before_2nd", n));
        rd(TCNT, 8'h02, $sformatf("psc%0d_2nd_tick", n));
    endtask

    initial begin
        // Reset reads, then write 0xFF everywhere and read back.
        vecs.push_back(mk(1'b0, TDR,   8'h00, 8'h00));
        vecs.push_back(mk(1'b0, TCR,   8'h00, 8'h00));
        vecs.push_back(mk(1'b0, TSR,   8'h00, 8'h00));
        vecs.push_back(mk(1'b0, TIER,  8'h00, 8'h00));
        vecs.push_back(mk(1'b0, TCNT,  8'h00, 8'h00));
        vecs.push_back(mk(1'b1, TCNT,  8'hFF, 8'h00));
        vecs.push_back(mk(1'b1, 8'h05, 8'hFF, 8'h00));
        vecs.push_back(mk(1'b1, 8'h06, 8'hFF, 8'h00));
        vecs.push_back(mk(1'b1, 8'h07, 8'hFF, 8'h00));
        vecs.push_back(mk(1'b1, 8'h80, 8'hFF, 8'h00));
        vecs.push_back(mk(1'b1, TSR,   8'hFF, 8'h00));
        vecs.push_back(mk(1'b1, TIER,  8'hFF, 8'h00));
        vecs.push_back(mk(1'b1, 8'h83, 8'h00, 8'h00));
        vecs.push_back(mk(1'b1, TDR,   8'hFF, 8'h00));
        vecs.push_back(mk(1'b0, TCNT,  8'h00, 8'h00));
        vecs.push_back(mk(1'b1, TCR,   8'hFF, 8'h00));
        vecs.push_back(mk(1'b0, TDR,   8'h00, 8'hFF));
        vecs.push_back(mk(1'b0, TCR,   8'h00, 8'hB3));
        vecs.push_back(mk(1'b0, TSR,   8'h00, 8'h00));
        vecs.push_back(mk(1'b0, TIER,  8'h00, 8'h03));
        vecs.push_back(mk(1'b0, 8'h06, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 8'h81, 8'h00, 8'h00));

        rst = 1'b1;
        step();
        started = 1'b1;
        step();
        rst = 1'b0;
        check("rst_int_ovf", {7'b0, int_ovf}, 8'h00);
        check("rst_int_udf", {7'b0, int_udf}, 8'h00);

        foreach (vecs[i])
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
                $sformatf("vec%0d_a%02h", i, vecs[i].addr));

        run_up(8'h00);
        run_up(8'h01);

        // Down count through 00->FF, W1C, then W1C colliding with a new underflow.
        do_reset();
        wr(TIER, 8'h02);
        wr(TDR, 8'h02);
        wr(TCR, 8'h80);
        wr(TCR, 8'h30);
        rd(TCNT, 8'h02, "dn_02");
        rd(TCNT, 8'h01, "dn_01");
        rd(TSR, 8'h00, "dn_tsr_preset_read");
        check("dn_int_udf_set", {7'b0, int_udf}, 8'h01);
        rd(TCNT, 8'hFF, "dn_ff");
        rd(TSR, 8'h02, "dn_tsr_udf");
        wr(TSR, 8'h02);
        check("dn_int_udf_cleared", {7'b0, int_udf}, 8'h00);
        rd(TSR, 8'h00, "dn_tsr_w1c");
        wr(TDR, 8'h00);
        wr(TCR, 8'hB0);
        wr(TCR, 8'h30);
        wr(TSR, 8'h02);
        check("dn_w1c_vs_set_int", {7'b0, int_udf}, 8'h01);
        rd(TSR, 8'h02, "dn_w1c_vs_set");

        presc(2'd3);
        presc(2'd1);
        presc(2'd2);

        // Reset mid-count at TCNT=7A with OVF set and a read in flight.
        do_reset();
        wr(TIER, 8'h03);
        wr(TDR, 8'hFF);
        wr(TCR, 8'h80);
        wr(TCR, 8'h10);
        wr(TDR, 8'h79);
        wr(TCR, 8'h80);
        wr(TCR, 8'h10);
        rd(TCNT, 8'h79, "mid_79");
        check("mid_int_ovf_before", {7'b0, int_ovf}, 8'h01);
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = TCNT;
        step();
        rst = 1'b0; req = 1'b0; addr = 8'h00;
        check("mid_int_ovf_after", {7'b0, int_ovf}, 8'h00);
        check("mid_int_udf_after", {7'b0, int_udf}, 8'h00);
        rd(TDR,  8'h00, "mid_tdr");
        rd(TCR,  8'h00, "mid_tcr");
        rd(TSR,  8'h00, "mid_tsr");
        rd(TIER, 8'h00, "mid_tier");
        rd(TCNT, 8'h00, "mid_tcnt");
        idle(4);
        rd(TCNT, 8'h00, "mid_no_resume");

        idle(3);
        check("sb_drained", sb.size()[7:0], 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/timer_8bit_core.md
Name: timer_8bit_core

Overview:
- Synthesizable 8-bit programmable timer: the DUT that the timer VIP agent drives and monitors.
- Register file on a simple request/acknowledge bus; clock prescaler (/1, /2, /4, /8); up/down counter with parallel load.
- Overflow and underflow status flags with per-flag interrupt enables.
- Sits between the system bus bridge (upstream) and the interrupt controller (downstream).

Parameters:
- ADDR_W, 8, bus address width. Only the low 3 bits are decoded; any upper bit set means a reserved address.
- RST_CNT, 8'h00, reset value of TCNT and TDR.

Ports:
- clk  in  1  sole clock; everything is on the rising edge.
- rst  in  1  reset; synchronous and active-high. Clears all state on the clk edge where rst=1.
- req  in  1  bus request; one transaction per cycle where req=1.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  ADDR_W  register address.
- wdata  in  8  write data.
- rdata  out  8  read data; valid when ack=1, else 8'h00.
- ack  out  1  one-cycle pulse, registered, the cycle after each req cycle.
- int_ovf  out  1  overflow interrupt = TSR.OVF & TIER.OVFE.
- int_udf  out  1  underflow interrupt = TSR.UDF & TIER.UDFE.

Behaviour:
- Register map:
  - 0x0 TDR: RW, load data.
  - 0x1 TCR: RW. [1:0] CKS; [4] EN; [5] DN (0 = up, 1 = down); [7] LOAD; bits 3, 2, 6 reserved.
  - 0x2 TSR: [0] OVF, [1] UDF; write 1 to clear, write 0 has no effect.
  - 0x3 TIER: RW. [0] OVFE, [1] UDFE.
  - 0x4 TCNT: RO.
  - 0x5-0x7 and all upper-bit addresses: reserved.
- Reserved bits and reserved addresses read 0; writes to them are ignored.
- Writes to TCNT are ignored and do not change TCNT.
- Reset values: TDR=RST_CNT, TCNT=RST_CNT, TCR=0, TSR=0, TIER=0, prescaler=0. Outputs after reset: rdata=0, ack=0, int_ovf=0, int_udf=0.
- Bus timing:
  - A write commits on the edge ending its req cycle.
  - A read samples the register at that same edge. rdata is driven with ack in the next cycle.
  - Back-to-back req cycles give back-to-back ack pulses.
  - A read in the cycle a flag is being set returns the pre-set value.
- Prescaler:
  - 3-bit counter; divisor N = 1, 2, 4, 8 for CKS = 0, 1, 2, 3.
  - While EN=1 and LOAD=0, the prescaler increments every cycle. It issues tick when its value equals N-1, then wraps to 0.
  - If EN=0, LOAD=1, or a TCR write changes CKS, the prescaler clears to 0 and no tick is issued.
  - First tick occurs N cycles after the edge that commits EN=1.
- Counter, on each tick:
  - Up: TCNT+1. If TCNT=8'hFF, it wraps to 8'h00 and sets OVF.
  - Down: TCNT-1. If TCNT=8'h00, it wraps to 8'hFF and sets UDF.
- LOAD=1: TCNT is loaded from TDR every cycle and counting is suppressed. LOAD stays set until software clears it.
- Clearing EN freezes TCNT; setting EN again resumes from the held value.
- A DN change takes effect from the next tick.
- Flags:
  - Set and W1C on the same edge: set wins.
  - Flags are sticky regardless of TIER.
  - int_* are combinational from the TSR and TIER flops, so they assert the cycle after the flag edge.
- rst=1 mid-operation: all state returns to reset values on that edge. A pending ack is dropped (ack=0 the next cycle).

Test Plan:
- Reset then read all 5 addresses → TDR=00, TCR=00, TSR=00, TIER=00, TCNT=00. Each read gets ack exactly 1 cycle after req.
- Write 0xFF to every address, then read back each:
  - TDR=FF, TCR=B3, TIER=03, TSR=00, TCNT=00.
  - Reserved address 0x6 reads 00.
- TDR=0xFD, TCR=0x80 then 0x10 (up, /1, EN) → TCNT follows FE, FF, 00, one per cycle. OVF=1 at the wrap. With TIER=0x01, int_ovf=1 the following cycle; with TIER=0, int_ovf stays 0.
- TDR=0x02, load, then TCR=0x30 (down) → TCNT 01, 00, FF. UDF=1. Write TSR=0x02 → UDF=0 and int_udf drops. A W1C landing on the same edge as a new underflow leaves UDF=1.
- TCR=0x13 (/8) from TCNT=0 → TCNT=1 exactly 8 cycles after the commit edge and 2 at 16 cycles. Repeat with CKS=1 and CKS=2 → periods of 2 and 4 cycles.
- rst=1 while counting at TCNT=0x7A with OVF set → next cycle all registers=0, ack=0, int_*=0. Counting does not resume until EN is rewritten.
